// File: rtl/fastram_arbiter.sv
// fastram_arbiter: shares the fastram SDRAM port between the 65C816 core (stalled via cpu_wait) and a DMA requester.
// Optional FASTRAM_ARB_RR_EN selects round-robin CPU/DMA priority; the default build gives the CPU fixed priority.
module fastram_arbiter #(
   parameter int         ACK_TIMEOUT = 64,
   parameter logic [7:0] ABORT_DATA  = 8'hFF
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [22:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic        cpu_wait,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [22:0] dma_addr,
   input  logic [7:0]  dma_din,
   output logic [7:0]  dma_dout,
   output logic        dma_ack,
   output logic [22:0] ram_address,
   output logic [7:0]  ram_datatoram,
   output logic        ram_we,
   output logic        ram_ce,
   input  logic [7:0]  ram_datafromram,
   input  logic        ram_ack,
   output logic        timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        owner_cpu;
   logic        cpu_pend;
   logic        pend_we;
   logic [22:0] pend_addr;
   logic [7:0]  pend_din;
   logic [7:0]  timer;
   logic        cpu_any;
   logic        grant_cpu;
   logic        grant;
   logic        ack_hit;
   logic        tmo_hit;
   logic        sel_we;
   logic [22:0] sel_addr;
   logic [7:0]  sel_din;

   assign cpu_any  = cpu_req | cpu_pend;
   assign cpu_wait = cpu_any;
   assign ram_ce   = (state == S_ISSUE);
   assign dma_ack  = (state == S_DONE) & ~owner_cpu;
   assign ack_hit  = (state == S_WAIT) & ram_ack;
   // An ack arriving on the last allowed cycle beats the timeout.
   assign tmo_hit  = (state == S_WAIT) & ~ram_ack & (timer == TIMER_LAST);

`ifdef FASTRAM_ARB_RR_EN
   logic last_cpu;

   assign grant_cpu = cpu_any & ~(dma_req & last_cpu);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         last_cpu <= 1'b0;
      end else if (grant) begin
         last_cpu <= grant_cpu;
      end
   end
`else
   assign grant_cpu = cpu_any;
`endif

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         S_IDLE: begin
            if (cpu_any || dma_req) begin
               grant     = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (ack_hit || tmo_hit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A CPU strobe arriving in IDLE is granted straight from the port inputs.
   always_comb begin
      sel_we   = dma_we;
      sel_addr = dma_addr;
      sel_din  = dma_din;
      if (grant_cpu) begin
         sel_we   = cpu_pend ? pend_we   : cpu_we;
         sel_addr = cpu_pend ? pend_addr : cpu_addr;
         sel_din  = cpu_pend ? pend_din  : cpu_din;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cpu_pend  <= 1'b0;
         pend_we   <= 1'b0;
         pend_addr <= '0;
         pend_din  <= '0;
      end else if (cpu_req && !cpu_pend) begin
         cpu_pend  <= 1'b1;
         pend_we   <= cpu_we;
         pend_addr <= cpu_addr;
         pend_din  <= cpu_din;
      end else if (state == S_DONE && owner_cpu) begin
         cpu_pend  <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         owner_cpu     <= 1'b0;
         ram_address   <= '0;
         ram_we        <= 1'b0;
         ram_datatoram <= '0;
      end else if (grant) begin
         owner_cpu     <= grant_cpu;
         ram_address   <= sel_addr;
         ram_we        <= sel_we;
         ram_datatoram <= sel_din;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else if (state == S_ISSUE) begin
         timer <= '0;
      end else if (state == S_WAIT && !ack_hit && !tmo_hit) begin
         timer <= timer + 8'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cpu_dout    <= '0;
         dma_dout    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (ack_hit && !ram_we) begin
            if (owner_cpu) begin
               cpu_dout <= ram_datafromram;
            end else begin
               dma_dout <= ram_datafromram;
            end
         end else if (tmo_hit && !ram_we) begin
            if (owner_cpu) begin
               cpu_dout <= ABORT_DATA;
            end else begin
               dma_dout <= ABORT_DATA;
            end
         end
         if (tmo_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule
